// File: rtl/data_mem_hs.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_hs
// Brief   : Byte-addressed little-endian data memory with valid/ready request
//           and response handshakes and a fixed access latency of LAT cycles.
// Revision: 1.0
// ============================================================================
module data_mem_hs #(
    parameter int ADDR_BITS = 16,
    parameter int LAT       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [3:0] c_cnt_init = 4'(LAT - 1);
    localparam int         c_bytes    = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [3:0]             r_cnt;
    logic [3:0]             w_cnt_nxt;
    logic                   r_we;
    logic [31:0]            r_addr;
    logic [31:0]            r_wdata;
    logic [2:0]             r_funct3;
    logic [7:0]             r_mem [c_bytes];

    logic                   w_accept;
    logic                   w_commit;
    logic                   w_we;
    logic [31:0]            w_addr;
    logic [31:0]            w_wdata;
    logic [2:0]             w_funct3;
    logic                   w_err;
    logic [ADDR_BITS-1:0]   w_a0;
    logic [ADDR_BITS-1:0]   w_a1;
    logic [ADDR_BITS-1:0]   w_a2;
    logic [ADDR_BITS-1:0]   w_a3;
    logic [31:0]            w_raw;
    logic [31:0]            w_load;
    logic [3:0]             w_be;

    assign req_ready  = rst & ((r_state == S_IDLE) | ((r_state == S_RESP) & resp_ready));
    assign w_accept   = req_valid & req_ready;
    assign resp_valid = (r_state == S_RESP);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE, S_RESP: begin
                if ((r_state == S_RESP) && resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
                if (w_accept) begin
                    w_cnt_nxt = c_cnt_init;
                    if (LAT > 1) begin
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_state_nxt = S_RESP;
                        w_commit    = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_RESP;
                    w_commit    = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // With LAT==1 the commit edge is the accepting edge, so use the live request.
    always_comb begin
        if (r_state == S_WAIT) begin
            w_we     = r_we;
            w_addr   = r_addr;
            w_wdata  = r_wdata;
            w_funct3 = r_funct3;
        end else begin
            w_we     = req_we;
            w_addr   = req_addr;
            w_wdata  = req_wdata;
            w_funct3 = req_funct3;
        end
    end

    always_comb begin
        w_err = (w_addr[31:ADDR_BITS] != '0);
        if (w_we) begin
            if (w_funct3 > 3'b010) w_err = 1'b1;
        end else if ((w_funct3 == 3'b011) || (w_funct3[2:1] == 2'b11)) begin
            w_err = 1'b1;
        end
        if ((w_funct3[1:0] == 2'b01) && w_addr[0]) w_err = 1'b1;
        if ((w_funct3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00)) w_err = 1'b1;
    end

    assign w_a0  = w_addr[ADDR_BITS-1:0];
    assign w_a1  = w_a0 + ADDR_BITS'(1);
    assign w_a2  = w_a0 + ADDR_BITS'(2);
    assign w_a3  = w_a0 + ADDR_BITS'(3);
    assign w_raw = {r_mem[w_a3], r_mem[w_a2], r_mem[w_a1], r_mem[w_a0]};

    always_comb begin
        w_load = '0;
        case (w_funct3)
            3'b000:  w_load = {{24{w_raw[7]}}, w_raw[7:0]};
            3'b001:  w_load = {{16{w_raw[15]}}, w_raw[15:0]};
            3'b010:  w_load = w_raw;
            3'b100:  w_load = {24'd0, w_raw[7:0]};
            3'b101:  w_load = {16'd0, w_raw[15:0]};
            default: w_load = '0;
        endcase
    end

    always_comb begin
        w_be = 4'b0000;
        if (w_commit && w_we && !w_err) begin
            case (w_funct3)
                3'b000:  w_be = 4'b0001;
                3'b001:  w_be = 4'b0011;
                3'b010:  w_be = 4'b1111;
                default: w_be = 4'b0000;
            endcase
        end
    end

    // The array is deliberately outside reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (w_be[0]) r_mem[w_a0] <= w_wdata[7:0];
        if (w_be[1]) r_mem[w_a1] <= w_wdata[15:8];
        if (w_be[2]) r_mem[w_a2] <= w_wdata[23:16];
        if (w_be[3]) r_mem[w_a3] <= w_wdata[31:24];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_funct3 <= '0;
        end else if (w_accept) begin
            r_we     <= req_we;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_funct3 <= req_funct3;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (w_commit) begin
            resp_err   <= w_err;
            resp_rdata <= (w_we || w_err) ? 32'd0 : w_load;
        end else if ((r_state == S_RESP) && resp_ready) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_hs.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_mem_hs
// Brief   : Scoreboard bench for data_mem_hs at LAT = 1, 2 and 5.
// Revision: 1.0
// ============================================================================
module tb_data_mem_hs;

    localparam int N = 3;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 5);
    endfunction

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid  [N];
    logic        req_ready  [N];
    logic        req_we     [N];
    logic [31:0] req_addr   [N];
    logic [31:0] req_wdata  [N];
    logic [2:0]  req_funct3 [N];
    logic        resp_valid [N];
    logic        resp_ready [N];
    logic [31:0] resp_rdata [N];
    logic        resp_err   [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        data_mem_hs #(.ADDR_BITS(16), .LAT(lat_of(g))) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_we     (req_we[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .req_funct3 (req_funct3[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g])
        );
    end

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          act    = 1;
    bit          seen   = 1'b0;
    bit          last_b2b = 1'b0;
    logic [31:0] q_rdata [$];
    logic        q_err   [$];
    int          q_acc   [$];
    string       q_name  [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: latency on first sight of each response, data on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            seen = 1'b0;
        end else begin
            if (resp_valid[act] && !seen) begin
                seen = 1'b1;
                if (q_acc.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got valid response with empty scoreboard");
                end else begin
                    check({q_name[0], "_lat"}, 32'(cyc - q_acc[0]), 32'(lat_of(act)));
                end
            end
            if (resp_valid[act] && resp_ready[act] && q_acc.size() != 0) begin
                check({q_name[0], "_rdata"}, resp_rdata[act], q_rdata[0]);
                check({q_name[0], "_err"}, 32'(resp_err[act]), 32'(q_err[0]));
                void'(q_rdata.pop_front());
                void'(q_err.pop_front());
                void'(q_acc.pop_front());
                void'(q_name.pop_front());
                seen = 1'b0;
            end
        end
    end

    task automatic issue(input int d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [2:0] f3,
                         input logic [31:0] er, input logic ee, input string name);
        int n = 0;
        req_valid[d]  = 1'b1;
        req_we[d]     = we;
        req_addr[d]   = addr;
        req_wdata[d]  = wd;
        req_funct3[d] = f3;
        @(negedge clk);
        while (!req_ready[d] && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready[d]) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: got no req_ready in 50 cycles, expected accept", name);
        end else begin
            last_b2b = resp_valid[d];
            q_rdata.push_back(er);
            q_err.push_back(ee);
            q_acc.push_back(cyc);
            q_name.push_back(name);
        end
        @(posedge clk);
        #1;
        req_valid[d]  = 1'b0;
        req_we[d]     = ~we;
        req_addr[d]   = 32'h0;
        req_wdata[d]  = 32'h5A5A_5A5A;
        req_funct3[d] = 3'b111;
    endtask

    task automatic drain();
        int n = 0;
        while (q_acc.size() != 0 && n < 100) begin
            n++;
            @(posedge clk);
        end
        checks++;
        if (q_acc.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding responses, expected 0", q_acc.size());
            q_rdata.delete(); q_err.delete(); q_acc.delete(); q_name.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int d, input string name);
        int n = 0;
        @(negedge clk);
        while (!resp_valid[d] && n < 50) begin
            n++;
            @(negedge clk);
        end
        check({name, "_valid_seen"}, 32'(resp_valid[d]), 32'd1);
    endtask

    task automatic basic(input int d);
        issue(d, 1'b1, 32'h100, 32'hDEAD_BEEF, 3'b010, 32'h0, 1'b0, "b_sw");
        issue(d, 1'b0, 32'h100, 32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0, "b_lw");
        issue(d, 1'b0, 32'h103, 32'h0, 3'b100, 32'h0000_00DE, 1'b0, "b_lbu");
        issue(d, 1'b0, 32'h101, 32'h0, 3'b000, 32'hFFFF_FFBE, 1'b0, "b_lb");
        issue(d, 1'b1, 32'h202, 32'h0000_8001, 3'b001, 32'h0, 1'b0, "b_sh");
        issue(d, 1'b0, 32'h202, 32'h0, 3'b101, 32'h0000_8001, 1'b0, "b_lhu");
        drain();
    endtask

    initial begin
        for (int d = 0; d < N; d++) begin
            req_valid[d]  = 1'b0;
            req_we[d]     = 1'b0;
            req_addr[d]   = 32'h0;
            req_wdata[d]  = 32'h0;
            req_funct3[d] = 3'b000;
            resp_ready[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready[1]), 32'd0);
        check("rst_resp_valid", 32'(resp_valid[1]), 32'd0);
        check("rst_resp_rdata", resp_rdata[1], 32'd0);
        check("rst_resp_err", 32'(resp_err[1]), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        act = 1;
        issue(1, 1'b1, 32'h100, 32'hDEAD_BEEF, 3'b010, 32'h0, 1'b0, "sw_100");
        issue(1, 1'b0, 32'h100, 32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0, "lw_100");
        issue(1, 1'b0, 32'h103, 32'h0, 3'b100, 32'h0000_00DE, 1'b0, "lbu_103");
        issue(1, 1'b0, 32'h101, 32'h0, 3'b000, 32'hFFFF_FFBE, 1'b0, "lb_101");
        drain();

        issue(1, 1'b1, 32'h200, 32'h4433_2211, 3'b010, 32'h0, 1'b0, "sw_200");
        issue(1, 1'b1, 32'h202, 32'h0000_8001, 3'b001, 32'h0, 1'b0, "sh_202");
        issue(1, 1'b0, 32'h202, 32'h0, 3'b001, 32'hFFFF_8001, 1'b0, "lh_202");
        issue(1, 1'b0, 32'h202, 32'h0, 3'b101, 32'h0000_8001, 1'b0, "lhu_202");
        issue(1, 1'b0, 32'h200, 32'h0, 3'b101, 32'h0000_2211, 1'b0, "lhu_200");
        issue(1, 1'b1, 32'h200, 32'hFFFF_FF77, 3'b000, 32'h0, 1'b0, "sb_200");
        issue(1, 1'b0, 32'h200, 32'h0, 3'b010, 32'h8001_2277, 1'b0, "lw_200");
        drain();

        issue(1, 1'b1, 32'h101, 32'h1111_1111, 3'b010, 32'h0, 1'b1, "sw_mis");
        issue(1, 1'b0, 32'h100, 32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0, "lw_after_mis");
        issue(1, 1'b0, 32'h102, 32'h0, 3'b010, 32'h0, 1'b1, "lw_mis");
        drain();

        resp_ready[1] = 1'b0;
        issue(1, 1'b0, 32'h100, 32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0, "lw_stall");
        wait_valid(1, "stall");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(resp_valid[1]), 32'd1);
            check("stall_rdata", resp_rdata[1], 32'hDEAD_BEEF);
            check("stall_err", 32'(resp_err[1]), 32'd0);
            check("stall_req_ready", 32'(req_ready[1]), 32'd0);
        end
        @(posedge clk);
        #1;
        resp_ready[1] = 1'b1;
        issue(1, 1'b0, 32'h203, 32'h0, 3'b100, 32'h0000_0080, 1'b0, "lbu_b2b");
        check("b2b_accept", 32'(last_b2b), 32'd1);
        drain();

        resp_ready[1] = 1'b0;
        issue(1, 1'b0, 32'h100, 32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0, "lw_rstresp");
        wait_valid(1, "rstresp");
        #2;
        rst = 1'b0;
        #1;
        check("rstresp_valid", 32'(resp_valid[1]), 32'd0);
        check("rstresp_rdata", resp_rdata[1], 32'd0);
        check("rstresp_req_ready", 32'(req_ready[1]), 32'd0);
        q_rdata.delete(); q_err.delete(); q_acc.delete(); q_name.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        resp_ready[1] = 1'b1;
        @(posedge clk);
        #1;

        req_valid[1]  = 1'b1;
        req_we[1]     = 1'b1;
        req_addr[1]   = 32'h100;
        req_wdata[1]  = 32'hCAFE_F00D;
        req_funct3[1] = 3'b010;
        @(negedge clk);
        check("abort_acc_ready", 32'(req_ready[1]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("abort_req_ready", 32'(req_ready[1]), 32'd0);
        check("abort_resp_valid", 32'(resp_valid[1]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        issue(1, 1'b0, 32'h100, 32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0, "lw_abort");
        drain();

        issue(1, 1'b0, 32'h0001_0000, 32'h0, 3'b010, 32'h0, 1'b1, "lw_range");
        issue(1, 1'b0, 32'h8000_0100, 32'h0, 3'b010, 32'h0, 1'b1, "lw_range_hi");
        issue(1, 1'b0, 32'h100, 32'h0, 3'b011, 32'h0, 1'b1, "ld_f3_011");
        issue(1, 1'b1, 32'h100, 32'h0, 3'b011, 32'h0, 1'b1, "st_f3_011");
        issue(1, 1'b0, 32'h201, 32'h0, 3'b001, 32'h0, 1'b1, "lh_mis");
        issue(1, 1'b0, 32'h100, 32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0, "lw_final");
        drain();

        act = 0;
        basic(0);
        act = 2;
        basic(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
